tdm_demux_1to4: RTL and testbench
=================================

# tdm_demux_1to4

Time-division demultiplexer: the receive end of the four-channel, 1-bit serial link driven by our 4-to-1 mux with a rotating select. Serial bits arrive one per slot, slots 0..3 in order, with a frame marker on slot 0. The block steers each bit to its channel, assembles WORD-bit words per channel over WORD frames, and presents all four words in parallel with a one-cycle valid strobe. It also detects loss of frame alignment and resynchronises.

## Interface
- WORD, 8, bits per channel word (≥2); frames per output word
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- din  in  1  serial data bit for the current slot
- din_valid  in  1  din/frame_sync sampled only when high
- frame_sync  in  1  high with the slot-0 bit of every frame
- ch0, ch1, ch2, ch3  out  WORD  last completed word per channel, registered
- ch_valid  out  1  one-cycle pulse: ch0..ch3 just updated
- slot  out  2  slot index expected for the next valid bit
- locked  out  1  high in LOCKED state
- sync_err  out  1  one-cycle pulse on a framing violation

## Operation
- States: HUNT, LOCKED. Reset: HUNT, slot=0, bit counter=0, shift regs=0, ch0..ch3=0, ch_valid=0, locked=0, sync_err=0.
- Cycles with din_valid=0: no state change, counters hold; ch_valid/sync_err low.
- HUNT: bits without frame_sync are discarded. A valid bit with frame_sync=1 is taken as slot 0 of frame 0: shifted into sh0, slot→1, state→LOCKED.
- LOCKED, valid bit:
  - frame_sync=1 and slot=0: normal; shift into sh0, slot→1.
  - frame_sync=0 and slot≠0: normal; shift into sh[slot], slot→slot+1 mod 4.
  - frame_sync=1 and slot≠0 (early marker): sync_err pulse, discard all partial words (shift regs and bit counter cleared), take this bit as slot 0 of a new frame 0, slot→1, remain LOCKED.
  - frame_sync=0 and slot=0 (missing marker): sync_err pulse, bit discarded, partial words cleared, state→HUNT, slot=0.
- Shift: sh[n] ← {sh[n][WORD-2:0], din}; first received bit ends in MSB.
- Bit counter 0..WORD-1 increments after each slot-3 bit. On the slot-3 bit with counter=WORD-1: ch0..ch3 ← completed words (ch3 includes the current bit), counter→0, ch_valid pulses. ch0..ch3 hold otherwise.
- slot wraps 3→0; counter wraps WORD-1→0; no other wrap states.

## Timing
- All outputs registered; update on the clk edge that samples the valid bit.
- ch_valid and updated ch0..ch3 are visible in the cycle after the edge sampling the final (slot-3, frame WORD-1) bit; ch_valid is high exactly one cycle.
- Latency first bit → ch_valid: 4·WORD valid bits plus one register stage; back-to-back valid bits supported every cycle, with continuous output words every 4·WORD valid cycles.
- sync_err asserts the cycle after the offending bit's edge, one cycle; locked falls in the same cycle for a missing marker.
- A marker error on the final bit of a word takes priority: no ch_valid, ch0..ch3 unchanged.
- rst mid-word: immediate return to reset values regardless of clk; partial words lost.

## Test plan
- Reset: assert rst with din_valid toggling -> ch0..ch3=0, ch_valid=0, locked=0, slot=0; deassert with no frame_sync -> stays HUNT.
- WORD=8, 32 back-to-back valid bits, frame_sync on every slot 0, channel words A5,3C,FF,01 sent MSB-first -> one ch_valid pulse, ch0=A5, ch1=3C, ch2=FF, ch3=01, one cycle after the 32nd bit.
- Same stream with din_valid low every other cycle -> identical words; ch_valid one cycle after the last valid bit; counters hold across gaps.
- Early frame_sync at slot 2 of frame 3 -> sync_err pulse, still locked, slot=1; next 32 bits carrying 11,22,33,44 -> ch0..ch3=11,22,33,44, previous outputs unchanged until then.
- Missing frame_sync at slot 0 -> sync_err, locked=0; bits ignored until next frame_sync; then a full word 80,40,20,10 is received correctly.
- rst pulsed mid-frame 5 -> outputs zeroed asynchronously; no ch_valid for the aborted word.

Source files
------------

// File: rtl/tdm_demux_if.sv
// Bus bundle between the serial TDM receiver and its parallel-word consumer.
// The slave modport is the demux side; the master modport is the link/bench side.
interface tdm_demux_if #(
  parameter int WORD = 8
) ();
  logic            din;
  logic            din_valid;
  logic            frame_sync;
  logic [WORD-1:0] ch0;
  logic [WORD-1:0] ch1;
  logic [WORD-1:0] ch2;
  logic [WORD-1:0] ch3;
  logic            ch_valid;
  logic [1:0]      slot;
  logic            locked;
  logic            sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  ch0, ch1, ch2, ch3, ch_valid, slot, locked, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output ch0, ch1, ch2, ch3, ch_valid, slot, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux_1to4.sv
// Four-channel 1-bit TDM demultiplexer: steers slot bits into per-channel shift
// registers, emits all four WORD-bit words together, and tracks frame alignment.
module tdm_demux_1to4 #(
  parameter int WORD = 8
) (
  input  logic        clk,
  input  logic        rst,
  tdm_demux_if.slave  bus
);

  localparam int              CNT_W    = (WORD > 2) ? $clog2(WORD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD - 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          state_q;
  logic [1:0]      slot_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WORD-1:0] sh_q [4];
  logic [WORD-1:0] ch_q [4];
  logic            ch_valid_q;
  logic            sync_err_q;
  logic            locked_q;

  logic [WORD-1:0] cur_shift_d;
  logic [WORD-1:0] first_bit_d;
  logic            early_mark;
  logic            miss_mark;

  // Next value of the channel register addressed by the current slot.
  always_comb begin
    cur_shift_d = {sh_q[slot_q][WORD-2:0], bus.din};
    first_bit_d = {{(WORD-1){1'b0}}, bus.din};
    early_mark  = bus.frame_sync && (slot_q != 2'd0);
    miss_mark   = !bus.frame_sync && (slot_q == 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HUNT;
      slot_q     <= 2'd0;
      cnt_q      <= '0;
      ch_valid_q <= 1'b0;
      sync_err_q <= 1'b0;
      locked_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        sh_q[i] <= '0;
        ch_q[i] <= '0;
      end
    end else begin
      ch_valid_q <= 1'b0;
      sync_err_q <= 1'b0;
      if (bus.din_valid) begin
        case (state_q)
          HUNT: begin
            if (bus.frame_sync) begin
              for (int i = 1; i < 4; i++) sh_q[i] <= '0;
              sh_q[0]  <= first_bit_d;
              cnt_q    <= '0;
              slot_q   <= 2'd1;
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
          end
          LOCKED: begin
            if (early_mark) begin
              // Marker arrived early: restart word assembly with this bit as slot 0.
              sync_err_q <= 1'b1;
              for (int i = 1; i < 4; i++) sh_q[i] <= '0;
              sh_q[0] <= first_bit_d;
              cnt_q   <= '0;
              slot_q  <= 2'd1;
            end else if (miss_mark) begin
              sync_err_q <= 1'b1;
              for (int i = 0; i < 4; i++) sh_q[i] <= '0;
              cnt_q    <= '0;
              slot_q   <= 2'd0;
              state_q  <= HUNT;
              locked_q <= 1'b0;
            end else begin
              sh_q[slot_q] <= cur_shift_d;
              slot_q       <= slot_q + 2'd1;
              if (slot_q == 2'd3) begin
                if (cnt_q == CNT_LAST) begin
                  // Channel 3 still holds one bit short; take its final bit directly.
                  ch_q[0]    <= sh_q[0];
                  ch_q[1]    <= sh_q[1];
                  ch_q[2]    <= sh_q[2];
                  ch_q[3]    <= cur_shift_d;
                  ch_valid_q <= 1'b1;
                  cnt_q      <= '0;
                end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
                end
              end
            end
          end
          default: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
            slot_q   <= 2'd0;
          end
        endcase
      end
    end
  end

  assign bus.ch0      = ch_q[0];
  assign bus.ch1      = ch_q[1];
  assign bus.ch2      = ch_q[2];
  assign bus.ch3      = ch_q[3];
  assign bus.ch_valid = ch_valid_q;
  assign bus.slot     = slot_q;
  assign bus.locked   = locked_q;
  assign bus.sync_err = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Randomised and directed bench for tdm_demux_1to4 with a queue-based frame model.
module tb_tdm_demux_1to4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  tdm_demux_if #(.WORD(W)) bus ();
  tdm_demux_1to4 #(.WORD(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int vcnt  = 0;

  // Model: accepted bits of the current word kept in arrival order.
  bit              m_locked = 1'b0;
  bit              mq[$];
  logic [W-1:0]    e_ch[4] = '{default: '0};
  bit              e_vld = 1'b0;
  bit              e_err = 1'b0;

  function automatic int m_slot();
    return m_locked ? (mq.size() % 4) : 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_locked = 1'b0;
      mq.delete();
      for (int n = 0; n < 4; n++) e_ch[n] = '0;
      e_vld = 1'b0;
      e_err = 1'b0;
    end else begin
      e_vld = 1'b0;
      e_err = 1'b0;
      if (bus.din_valid) begin
        if (!m_locked) begin
          if (bus.frame_sync) begin
            mq.delete();
            mq.push_back(bus.din);
            m_locked = 1'b1;
          end
        end else if (bus.frame_sync && (mq.size() % 4) != 0) begin
          e_err = 1'b1;
          mq.delete();
          mq.push_back(bus.din);
        end else if (!bus.frame_sync && (mq.size() % 4) == 0) begin
          e_err = 1'b1;
          mq.delete();
          m_locked = 1'b0;
        end else begin
          mq.push_back(bus.din);
          if (mq.size() == 4 * W) begin
            for (int n = 0; n < 4; n++)
              for (int f = 0; f < W; f++)
                e_ch[n][W-1-f] = mq[4*f+n];
            e_vld = 1'b1;
            mq.delete();
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("ch0", 32'(bus.ch0), 32'(e_ch[0]));
    chk("ch1", 32'(bus.ch1), 32'(e_ch[1]));
    chk("ch2", 32'(bus.ch2), 32'(e_ch[2]));
    chk("ch3", 32'(bus.ch3), 32'(e_ch[3]));
    chk("ch_valid", 32'(bus.ch_valid), 32'(e_vld));
    chk("sync_err", 32'(bus.sync_err), 32'(e_err));
    chk("locked", 32'(bus.locked), 32'(m_locked));
    chk("slot", 32'(bus.slot), 32'(m_slot()));
  end

  always @(posedge clk) if (bus.ch_valid === 1'b1) vcnt++;

  task automatic send_bit(input bit d, input bit fs, input bit gap);
    if (gap) begin
      @(negedge clk);
      bus.din_valid  = 1'b0;
      bus.din        = 1'($urandom);
      bus.frame_sync = 1'($urandom);
    end
    @(negedge clk);
    bus.din_valid  = 1'b1;
    bus.din        = d;
    bus.frame_sync = fs;
  endtask

  // Sends bit indices [start, stop) of a four-word frame group, MSB first per channel.
  task automatic send_word(input logic [W-1:0] w0, input logic [W-1:0] w1,
                           input logic [W-1:0] w2, input logic [W-1:0] w3,
                           input int start, input int stop, input bit gap);
    logic [W-1:0] w[4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int k = start; k < stop; k++)
      send_bit(w[k%4][W-1-(k/4)], (k % 4) == 0, gap);
  endtask

  task automatic end_burst();
    @(negedge clk);
    bus.din_valid = 1'b0;
  endtask

  task automatic chk_words(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d);
    chk({tag, "_vld"}, 32'(bus.ch_valid), 32'd1);
    chk({tag, "_ch0"}, 32'(bus.ch0), 32'(a));
    chk({tag, "_ch1"}, 32'(bus.ch1), 32'(b));
    chk({tag, "_ch2"}, 32'(bus.ch2), 32'(c));
    chk({tag, "_ch3"}, 32'(bus.ch3), 32'(d));
  endtask

  initial begin
    int v0;
    bus.din_valid  = 1'b0;
    bus.din        = 1'b0;
    bus.frame_sync = 1'b0;
    #1 rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      bus.din_valid  = 1'($urandom);
      bus.din        = 1'($urandom);
      bus.frame_sync = 1'($urandom);
    end
    @(negedge clk);
    chk("rst_ch0", 32'(bus.ch0), 32'd0);
    chk("rst_locked", 32'(bus.locked), 32'd0);
    chk("rst_slot", 32'(bus.slot), 32'd0);
    chk("rst_vld", 32'(bus.ch_valid), 32'd0);
    bus.din_valid = 1'b0;
    #2 rst = 1'b0;

    repeat (6) send_bit(1'($urandom), 1'b0, 1'b0);
    end_burst();
    chk("hunt_locked", 32'(bus.locked), 32'd0);

    send_word(8'hA5, 8'h3C, 8'hFF, 8'h01, 0, 32, 1'b0);
    end_burst();
    chk_words("b2b", 8'hA5, 8'h3C, 8'hFF, 8'h01);
    repeat (3) @(negedge clk);

    send_word(8'hA5, 8'h3C, 8'hFF, 8'h01, 0, 32, 1'b1);
    end_burst();
    chk_words("gap", 8'hA5, 8'h3C, 8'hFF, 8'h01);

    send_word(8'h55, 8'h66, 8'h77, 8'h88, 0, 14, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0);
    end_burst();
    chk("early_err", 32'(bus.sync_err), 32'd1);
    chk("early_locked", 32'(bus.locked), 32'd1);
    chk("early_slot", 32'(bus.slot), 32'd1);
    chk("early_hold", 32'(bus.ch0), 32'hA5);
    send_word(8'h11, 8'h22, 8'h33, 8'h44, 1, 32, 1'b0);
    end_burst();
    chk_words("early", 8'h11, 8'h22, 8'h33, 8'h44);

    send_word(8'h99, 8'h99, 8'h99, 8'h99, 0, 4, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    end_burst();
    chk("miss_err", 32'(bus.sync_err), 32'd1);
    chk("miss_locked", 32'(bus.locked), 32'd0);
    repeat (5) send_bit(1'($urandom), 1'b0, 1'b0);
    end_burst();
    chk("miss_hunt", 32'(bus.locked), 32'd0);
    send_word(8'h80, 8'h40, 8'h20, 8'h10, 0, 32, 1'b0);
    end_burst();
    chk_words("relock", 8'h80, 8'h40, 8'h20, 8'h10);

    repeat (3000) begin
      @(negedge clk);
      bus.din_valid = ($urandom % 4) != 0;
      bus.din       = 1'($urandom);
      if (!m_locked) bus.frame_sync = ($urandom % 3) == 0;
      else           bus.frame_sync = (m_slot() == 0) ^ (($urandom % 64) == 0);
    end
    end_burst();

    send_word(8'h80, 8'h40, 8'h20, 8'h10, 0, 32, 1'b0);
    end_burst();
    send_word(8'h12, 8'h34, 8'h56, 8'h78, 0, 22, 1'b0);
    end_burst();
    v0 = vcnt;
    #2 rst = 1'b1;
    #1;
    chk("arst_ch0", 32'(bus.ch0), 32'd0);
    chk("arst_ch3", 32'(bus.ch3), 32'd0);
    chk("arst_locked", 32'(bus.locked), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    send_word(8'h12, 8'h34, 8'h56, 8'h78, 22, 32, 1'b0);
    end_burst();
    repeat (3) @(negedge clk);
    chk("arst_no_vld", 32'(vcnt), 32'(v0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
